// File: rtl/lsu_mem_responder.sv
// +--------------------------------------------------------------------------+
// | lsu_mem_responder : load/store memory responder with wait states          |
// | Optional MEM_BOUNDS_CHECK_EN flags out-of-range/misaligned accesses.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module lsu_mem_responder #(
  parameter int                XLEN      = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [XLEN-1:0]   BASE_ADDR = 32'h0000_0000,
  parameter int                LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req,
  input  logic                we,
  input  logic [XLEN-1:0]     addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [XLEN/8-1:0]   byte_en,
  output logic                ready,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rd_data,
  output logic                err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  hold_we;
  logic [XLEN-1:0]       hold_addr;
  logic [XLEN-1:0]       hold_wdata;
  logic [LANES-1:0]      hold_be;

  logic [XLEN-1:0]       mem [DEPTH];

  logic [XLEN-1:0]       offset;
  logic [AW-1:0]         idx;
  logic                  do_access;
  logic                  access_err;
  logic                  unused_bits;

  assign offset      = hold_addr - BASE_ADDR;
  assign idx         = offset[AW+1:2];
  assign unused_bits = ^{offset[XLEN-1:AW+2], offset[1:0]};
  assign do_access   = (state == WAIT) && (cnt == 4'd0);

`ifdef MEM_BOUNDS_CHECK_EN
  // One extra bit keeps BASE_ADDR + 4*DEPTH from overflowing at the top of the map.
  localparam logic [XLEN:0] LIMIT = {1'b0, BASE_ADDR} + (XLEN+1)'(4 * DEPTH);
  assign access_err = (hold_addr < BASE_ADDR) ||
                      ({1'b0, hold_addr} >= LIMIT) ||
                      (hold_addr[1:0] != 2'b00);
`else
  assign access_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      ready      <= 1'b1;
      rsp_valid  <= 1'b0;
      rd_data    <= '0;
      err        <= 1'b0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_be    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (req) begin
            hold_we    <= we;
            hold_addr  <= addr;
            hold_wdata <= wr_data;
            hold_be    <= byte_en;
            cnt        <= 4'(LATENCY);
            state      <= WAIT;
            ready      <= 1'b0;
          end else begin
            state      <= IDLE;
            ready      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            ready     <= 1'b1;
            rsp_valid <= 1'b1;
            err       <= access_err;
            if (!hold_we) begin
              rd_data <= access_err ? '0 : mem[idx];
            end
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rstn.
  always_ff @(posedge clk) begin
    if (do_access && hold_we && !access_err) begin
      for (int i = 0; i < LANES; i++) begin
        if (hold_be[i]) begin
          mem[idx][8*i +: 8] <= hold_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_responder.sv
// +--------------------------------------------------------------------------+
// | tb_lsu_mem_responder : randomized bench against a word-array model        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_mem_responder;

  localparam int          XLEN    = 32;
  localparam int          DEPTH   = 1024;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  byte_en;
  logic        ready;
  logic        rsp_valid;
  logic [31:0] rd_data;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  lsu_mem_responder #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .LATENCY   (LATENCY)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wr_data   (wr_data),
    .byte_en   (byte_en),
    .ready     (ready),
    .rsp_valid (rsp_valid),
    .rd_data   (rd_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) >> 2;
    return int'(w % DEPTH);
  endfunction

  function automatic bit is_err(input logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return (a < BASE) || ({32'h0, a} >= ({32'h0, BASE} + 64'(4 * DEPTH))) || (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One complete transaction, checked against the word-array model.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input string tag);
    int n;
    bit e;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wr_data = d; byte_en = be;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    e = is_err(a);
    if (!w) begin
      last_rd = e ? 32'h0 : model[widx(a)];
    end else if (!e) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
      end
    end
    check({tag, "_latency"}, 32'(n), 32'(LATENCY + 1));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_rd_data"}, rd_data, last_rd);
    @(negedge clk);
    check({tag, "_single_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int k, got, last;
    bit pend;
    logic [31:0] old, a;
    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wr_data = '0; byte_en = '0;
    last_rd = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_err", 32'(err), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 32; i++) xfer(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, "init");

    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
    xfer(1'b0, 32'h10, 32'h0, 4'h0, "rd10");
    check("rd10_value", rd_data, 32'hDEADBEEF);

    xfer(1'b1, 32'h20, 32'h11223344, 4'hF, "wr20_full");
    xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "wr20_part");
    xfer(1'b0, 32'h20, 32'h0, 4'h0, "rd20");
    check("rd20_value", rd_data, 32'h11BB33DD);

    // Back-to-back reads with req held high.
    k = 0; got = 0; last = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = BASE; byte_en = 4'h0;
    pend = ready;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("b2b_data", rd_data, model[widx(BASE + 32'(4 * got))]);
        if (got > 0) check("b2b_gap", 32'(cyc - last), 32'(LATENCY + 2));
        last = cyc;
        got++;
      end
      if (pend) begin
        check("b2b_wait_ready", 32'(ready), 32'd0);
        k++;
        if (k < 4) addr = BASE + 32'(4 * k);
        else req = 1'b0;
      end
      pend = req && ready;
    end
    req = 1'b0;
    check("b2b_count", 32'(got), 32'd4);
    last_rd = model[widx(BASE + 32'd12)];

    // Reset while the write is still waiting.
    old = model[widx(32'h40)];
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; wr_data = 32'h12345678; byte_en = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rstn = 1'b0;
    #1;
    check("midwait_ready", 32'(ready), 32'd1);
    check("midwait_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    last_rd = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midwait_no_rsp", 32'(rsp_valid), 32'd0);
    end
    xfer(1'b0, 32'h40, 32'h0, 4'h0, "rd40");
    check("rd40_old", rd_data, old);

`ifdef MEM_BOUNDS_CHECK_EN
    xfer(1'b0, 32'h1002, 32'h0, 4'h0, "oob_misaligned");
    check("oob_misaligned_err", 32'(err), 32'd1);
    xfer(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, "oob_top");
    check("oob_top_rd", rd_data, 32'h0);
    old = model[0];
    xfer(1'b1, BASE + 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, "oob_write");
    xfer(1'b0, BASE, 32'h0, 4'h0, "rd_base");
    check("oob_mem_unchanged", rd_data, old);
`else
    xfer(1'b1, BASE + 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, "wrap_write");
    xfer(1'b0, BASE, 32'h0, 4'h0, "wrap_read");
    check("wrap_value", rd_data, 32'hCAFEF00D);
    check("wrap_err", 32'(err), 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      a = BASE + 32'(4 * $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'(4 * DEPTH);
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

Memory-side responder for the core's load/store port. It accepts one word-wide read or write request at a time, inserts a configurable number of wait states, performs the access on an internal word-addressed array with byte-enable writes, and returns a single-cycle completion pulse with read data. It sits outside the core and serves as the data-memory end of the load/store interface, both in system builds and as the data-memory model in core benches.

## Interface
- XLEN, 32: data and address width in bits.
- DEPTH, 1024: memory size in XLEN-bit words (power of two).
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- LATENCY, 2: wait states between acceptance and the access (0..15).

Ports:
- clk  in  1  clock; all state on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req  in  1  request valid.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  XLEN  byte address; sampled with req.
- wr_data  in  XLEN  write data; sampled with req.
- byte_en  in  XLEN/8  write byte lanes; ignored for reads.
- ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  one-cycle completion pulse, for reads and writes.
- rd_data  out  XLEN  read data; valid when rsp_valid=1 for a read.
- err  out  1  access error, qualified by rsp_valid.

## Operation
- FSM states: IDLE, WAIT, RESP.
- Acceptance: req=1 and ready=1 at a rising edge. we, addr, wr_data and byte_en are captured into holding registers. req while ready=0 is ignored, and the requester holds req.
- ready=1 in IDLE and RESP, and 0 in WAIT.
- IDLE: on acceptance, go to WAIT with cnt=LATENCY.
- WAIT: if cnt≠0, decrement. If cnt=0, perform the access and go to RESP.
- RESP: rsp_valid=1. On acceptance, go to WAIT with cnt=LATENCY. Otherwise go to IDLE.
- Word index = (addr−BASE_ADDR)>>2, truncated to log2(DEPTH) bits.
- Read: rd_data ← mem[index], the full word regardless of byte_en.
- Write: for each lane i with byte_en[i]=1, mem[index][8i+7:8i] ← wr_data[8i+7:8i]. A write with byte_en=0 changes nothing but still completes. rd_data is unchanged on a write response.
- Memory contents are not reset and are preserved across rstn.

## Timing
- Reset values: ready=1, rsp_valid=0, rd_data=0, err=0, state=IDLE, cnt=0.
- Latency: acceptance at edge E → rsp_valid high during the cycle after edge E+LATENCY+1. With LATENCY=0, rsp_valid is high the cycle after E+1.
- Back-to-back: acceptance during RESP gives one access per LATENCY+2 cycles.
- rsp_valid is never high for two consecutive cycles.
- Read-after-write to the same word returns the written data, because accesses are serialized.
- Reset mid-operation (WAIT or RESP): the FSM returns to IDLE immediately and the outstanding request is dropped. The write is not performed if still in WAIT, and no rsp_valid is issued.
- rd_data holds its value between responses.

## Configuration
- MEM_BOUNDS_CHECK_EN defined:
  - An access is an error if addr < BASE_ADDR, addr ≥ BASE_ADDR+4·DEPTH, or addr[1:0]≠0.
  - An erroring access does not touch memory. It completes with normal timing, with rsp_valid=1, err=1, and rd_data=0 for reads.
  - err is 0 on valid responses.
- MEM_BOUNDS_CHECK_EN undefined:
  - err is tied to 0.
  - addr[1:0] is ignored and out-of-range addresses wrap modulo DEPTH words.

## Test plan
- Reset values, then write and read back: LATENCY=2. Check reset values. Write 0xDEADBEEF to 0x10 with byte_en=4'hF, then read 0x10. Expect rsp_valid exactly 3 cycles after each acceptance edge and rd_data=0xDEADBEEF.
- Partial write: with mem[0x20]=0x11223344, write 0xAABBCCDD with byte_en=4'b0101, then read 0x20. Expect 0x11BB33DD.
- Back-to-back: hold req high for 4 reads of 0x0, 0x4, 0x8 and 0xC. Expect ready low during WAIT, completions 4 cycles apart, and data in order.
- Reset mid-WAIT: accept a write of 0x12345678 to 0x40, assert rstn=0 during WAIT, then read 0x40. Expect no rsp_valid from the dropped write and the old contents returned.
- Bounds (macro on): read 0x1002 and read BASE_ADDR+4·DEPTH. Expect rsp_valid=1, err=1, rd_data=0, and memory unchanged.
- Wrap (macro off): write 0xCAFEF00D to BASE_ADDR+4·DEPTH, then read BASE_ADDR. Expect 0xCAFEF00D and err=0.
